// File: rtl/sd_pkg.sv
// Shared definitions for the sync-frame transmitter and the sequence
// detectors that consume its stream.
//   sd_state_e      : transmitter FSM states
//   SYNC_W_DFLT     : default sync marker width
//   SYNC_PATTERN    : default sync marker, sent MSB first
//   IDLE_LEVEL_DFLT : default line level in idle and guard gap
//   cnt_width()     : bit-counter width, $clog2(max(a,b,c)) + 1
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_GAP    = 3'd4
  } sd_state_e;

  localparam int                     SYNC_W_DFLT     = 4;
  localparam logic [SYNC_W_DFLT-1:0] SYNC_PATTERN    = 4'b1011;
  localparam logic                   IDLE_LEVEL_DFLT = 1'b0;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in / serial-out shift register.
//   clk, rst_n : clock, async active-low reset (clears to zero)
//   i_load     : load i_data (wins over i_shift)
//   i_data     : parallel word
//   i_shift    : shift left by one, zero fill
//   o_msb      : current MSB
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_shift,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_sh;

  generate
    if (WIDTH == 1) begin : g_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_sh <= '0;
        else if (i_load)  r_sh <= i_data;
        else if (i_shift) r_sh <= '0;
      end
    end else begin : g_wide
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_sh <= '0;
        else if (i_load)  r_sh <= i_data;
        else if (i_shift) r_sh <= {r_sh[WIDTH-2:0], 1'b0};
      end
    end
  endgenerate

  assign o_msb = r_sh[WIDTH-1];

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: each accepted word goes out as
// sync marker (MSB first), payload (MSB first), even parity, guard gap.
//   clk, rst_n   : clock, async active-low reset
//   tx_data      : payload, sampled only on the accept edge
//   tx_valid     : producer has a word
//   tx_ready     : high only in IDLE
//   serial_out   : registered serial line
//   frame_active : high for every sync/data/parity/gap bit
//   done         : one-cycle pulse in the first IDLE cycle after a frame
module sync_frame_tx
  import sd_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                SYNC_W     = SYNC_W_DFLT,
  parameter logic [SYNC_W-1:0] SYNC       = SYNC_PATTERN,
  parameter int                GAP_BITS   = 2,
  parameter logic              IDLE_LEVEL = IDLE_LEVEL_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              serial_out,
  output logic              frame_active,
  output logic              done
);

  localparam int               CNT_W     = cnt_width(DATA_W, SYNC_W, GAP_BITS);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_BITS - 1);

  sd_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_par, r_ser, r_active, r_done;
  logic             w_accept, w_shift, w_msb;
  logic             w_ser_nxt, w_active_nxt, w_done_nxt;

  assign tx_ready = (r_state == ST_IDLE);
  assign w_accept = tx_valid && tx_ready;

  // Shift whenever the upcoming cycle is a data cycle: the MSB is captured
  // into r_ser on the same edge, so the register always holds the next bit.
  assign w_shift = (w_state_nxt == ST_DATA);

  piso_shift #(.WIDTH(DATA_W)) u_piso (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_accept),
    .i_data  (tx_data),
    .i_shift (w_shift),
    .o_msb   (w_msb)
  );

  // State register and shared bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state; the counter restarts on every state change and rests in IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept)           w_state_nxt = ST_SYNC;
      ST_SYNC:   if (r_cnt == SYNC_LAST) w_state_nxt = ST_DATA;
      ST_DATA:   if (r_cnt == DATA_LAST) w_state_nxt = ST_PARITY;
      ST_PARITY:                         w_state_nxt = ST_GAP;
      ST_GAP:    if (r_cnt == GAP_LAST)  w_state_nxt = ST_IDLE;
      default:                           w_state_nxt = ST_IDLE;
    endcase
    if ((w_state_nxt != r_state) || (r_state == ST_IDLE)) w_cnt_nxt = '0;
    else                                                  w_cnt_nxt = r_cnt + CNT_W'(1);
  end

  // Output decode of the upcoming cycle; registered below so the line has
  // no combinational path from the inputs.
  always_comb begin
    w_ser_nxt    = IDLE_LEVEL;
    w_active_nxt = 1'b1;
    case (w_state_nxt)
      ST_SYNC: begin
        for (int k = 0; k < SYNC_W; k++)
          if (w_cnt_nxt == CNT_W'(k)) w_ser_nxt = SYNC[SYNC_W-1-k];
      end
      ST_DATA:   w_ser_nxt = w_msb;
      ST_PARITY: w_ser_nxt = r_par;
      ST_GAP:    w_ser_nxt = IDLE_LEVEL;
      default:   w_active_nxt = 1'b0;
    endcase
    w_done_nxt = (r_state == ST_GAP) && (w_state_nxt == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ser    <= IDLE_LEVEL;
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_par    <= 1'b0;
    end else begin
      r_ser    <= w_ser_nxt;
      r_active <= w_active_nxt;
      r_done   <= w_done_nxt;
      if (w_accept) r_par <= ^tx_data;
    end
  end

  assign serial_out   = r_ser;
  assign frame_active = r_active;
  assign done         = r_done;

endmodule

// File: tb/tb_sync_frame_tx.sv
module tb_sync_frame_tx;

  localparam int         DATA_W   = 8;
  localparam int         SYNC_W   = 4;
  localparam int         GAP_BITS = 2;
  localparam logic [3:0] SYNC_P   = 4'b1011;

  typedef struct packed {
    logic ser;
    logic act;
    logic rdy;
    logic done;
    logic sync_end;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, serial_out, frame_active, done;

  int          nvec = 0;
  int          nerr = 0;
  int          cyc = 0;
  exp_t        q[$];
  int          acc_t[$];
  logic [3:0]  hist = '0;
  logic [14:0] cap = '0;
  bit          det_en = 1'b0;

  sync_frame_tx #(
    .DATA_W(DATA_W), .SYNC_W(SYNC_W), .SYNC(SYNC_P),
    .GAP_BITS(GAP_BITS), .IDLE_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .serial_out(serial_out),
    .frame_active(frame_active), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  function automatic exp_t idle_rec();
    exp_t e;
    e = '{ser: 1'b0, act: 1'b0, rdy: 1'b1, done: 1'b0, sync_end: 1'b0};
    return e;
  endfunction

  // Reference frame: the cycle-by-cycle line picture of one frame plus the done cycle
  task automatic push_frame(input logic [7:0] d);
    logic [3:0] s;
    exp_t e;
    s = SYNC_P;
    for (int i = 0; i < SYNC_W; i++) begin
      e = '{ser: s[SYNC_W-1-i], act: 1'b1, rdy: 1'b0, done: 1'b0, sync_end: (i == SYNC_W-1)};
      q.push_back(e);
    end
    for (int i = 0; i < DATA_W; i++) begin
      e = '{ser: d[DATA_W-1-i], act: 1'b1, rdy: 1'b0, done: 1'b0, sync_end: 1'b0};
      q.push_back(e);
    end
    e = '{ser: ^d, act: 1'b1, rdy: 1'b0, done: 1'b0, sync_end: 1'b0};
    q.push_back(e);
    for (int i = 0; i < GAP_BITS; i++) begin
      e = '{ser: 1'b0, act: 1'b1, rdy: 1'b0, done: 1'b0, sync_end: 1'b0};
      q.push_back(e);
    end
    e = '{ser: 1'b0, act: 1'b0, rdy: 1'b1, done: 1'b1, sync_end: 1'b0};
    q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t cur;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      q.delete();
    end else begin
      cur = (q.size() > 0) ? q[0] : idle_rec();
      if (q.size() > 0) void'(q.pop_front());
      if (cur.rdy && tx_valid) begin
        push_frame(tx_data);
        acc_t.push_back(cyc);
      end
    end
    @(negedge clk);
    cur = (q.size() > 0) ? q[0] : idle_rec();
    chk("serial_out", serial_out, cur.ser);
    chk("frame_active", frame_active, cur.act);
    chk("tx_ready", tx_ready, cur.rdy);
    chk("done", done, cur.done);
    hist = {hist[2:0], serial_out};
    if (frame_active) cap = {cap[13:0], serial_out};
    if (det_en) chk("detector", (hist == 4'b1011), cur.sync_end);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst serial_out", serial_out, 1'b0);
    chk("rst frame_active", frame_active, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst tx_ready", tx_ready, 1'b1);
    rst_n = 1'b1;

    // Quiet line after release
    repeat (20) tick();

    // 0xA5: 1011 10100101 0 00
    cap = '0;
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (16) tick();
    chk_int("stream A5", int'(cap), int'(15'b1011_10100101_0_00));

    // 0x01: parity 1
    cap = '0;
    tx_data = 8'h01; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (16) tick();
    chk_int("stream 01", int'(cap), int'(15'b1011_00000001_1_00));

    // Back-to-back, valid held: 0x3C then 0xFF
    acc_t.delete();
    tx_data = 8'h3C; tx_valid = 1'b1;
    tick();
    tx_data = 8'hFF;
    repeat (16) tick();
    tx_valid = 1'b0;
    repeat (17) tick();
    chk_int("b2b accepts", acc_t.size(), 2);
    if (acc_t.size() == 2) chk_int("b2b spacing", acc_t[1] - acc_t[0], 16);

    // Payload scrambled every cycle during the frame
    tx_data = 8'h96; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (15) begin
      tx_data = 8'($urandom);
      tick();
    end
    repeat (2) tick();

    // Fully random valid/data traffic
    repeat (200) begin
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = 8'($urandom);
      tick();
    end
    tx_valid = 1'b0;
    repeat (17) tick();

    // Reset during data bit 3
    tx_data = 8'($urandom); tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (7) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async serial_out", serial_out, 1'b0);
    chk("async tx_ready", tx_ready, 1'b1);
    chk("async frame_active", frame_active, 1'b0);
    chk("async done", done, 1'b0);
    q.delete();
    hist = '0;
    tick();
    rst_n = 1'b1;

    // Zero payload frames after release, detector enabled
    det_en = 1'b1;
    tx_data = 8'h00; tx_valid = 1'b1;
    repeat (33) tick();
    tx_valid = 1'b0;
    repeat (18) tick();
    det_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
